sleep_request_gen: RTL and testbench

- Upstream companion of the core's sleep controller.
- Turns pipeline-level events into the single-cycle sleep_request / wakeup_request pulses the sleep controller consumes:
  - a retired WFI, or an idle-cycle timeout, triggers sleep entry;
  - masked wake sources trigger wake.
- Drains the pipeline before requesting sleep and records which source caused each wake.
- Sits between the WB-stage / interrupt logic and the sleep controller; closes the loop by monitoring the controller's sleep-state output.

---
 rtl/sleep_request_gen.sv | 115 +++++++++++
 tb/tb_sleep_request_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sleep_request_gen.sv
// Sleep/wake request generator: drains the pipeline on WFI or idle timeout, issues
// one-cycle sleep/wakeup pulses to the sleep controller and records the wake cause.
module sleep_request_gen #(
  parameter int NUM_WAKE_SRC   = 4,
  parameter int IDLE_THRESHOLD = 16,
  parameter int CNT_W          = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wfi_valid,
  input  logic                    pipe_active,
  input  logic                    pipe_empty,
  input  logic                    auto_sleep_en,
  input  logic [NUM_WAKE_SRC-1:0] wake_src,
  input  logic [NUM_WAKE_SRC-1:0] wake_mask,
  input  logic                    sleep_state,
  output logic                    drain_req,
  output logic                    sleep_request,
  output logic                    wakeup_request,
  output logic [NUM_WAKE_SRC-1:0] wake_cause,
  output logic [2:0]              gen_state
);

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_SLEEP_WAIT = 3'd2,
    ST_ASLEEP     = 3'd3,
    ST_WAKE_WAIT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] THR    = CNT_W'(IDLE_THRESHOLD);
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(IDLE_THRESHOLD - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        idle_cnt_q, idle_cnt_d;
  logic                    pend_q, pend_d;
  logic                    drain_q, drain_d;
  logic                    sreq_q, sreq_d;
  logic                    wreq_q, wreq_d;
  logic [NUM_WAKE_SRC-1:0] cause_q, cause_d;

  logic [NUM_WAKE_SRC-1:0] wake_hits;
  logic                    wake_pend;
  logic                    trigger;
  logic                    pend_now;

  assign wake_hits = wake_src & wake_mask;
  assign wake_pend = |wake_hits;
  assign trigger   = wfi_valid | (auto_sleep_en & ~pipe_active & (idle_cnt_q == THR_M1));
  // A wake arriving in the same cycle the controller reports sleep still counts.
  assign pend_now  = pend_q | wake_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      idle_cnt_q <= '0;
      pend_q     <= 1'b0;
      drain_q    <= 1'b0;
      sreq_q     <= 1'b0;
      wreq_q     <= 1'b0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      pend_q     <= pend_d;
      drain_q    <= drain_d;
      sreq_q     <= sreq_d;
      wreq_q     <= wreq_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:        if (trigger && !wake_pend) state_d = ST_DRAIN;
      // Never request sleep while the controller still reports asleep.
      ST_DRAIN: begin
        if (wake_pend)                      state_d = ST_RUN;
        else if (pipe_empty && !sleep_state) state_d = ST_SLEEP_WAIT;
      end
      ST_SLEEP_WAIT: if (sleep_state) state_d = pend_now ? ST_WAKE_WAIT : ST_ASLEEP;
      ST_ASLEEP:     if (wake_pend)   state_d = ST_WAKE_WAIT;
      ST_WAKE_WAIT:  if (!sleep_state) state_d = ST_RUN;
      default:       state_d = ST_RUN;
    endcase
  end

  always_comb begin
    idle_cnt_d = '0;
    pend_d     = 1'b0;
    cause_d    = cause_q;
    drain_d    = (state_d != ST_RUN);
    sreq_d     = (state_q == ST_DRAIN) && (state_d == ST_SLEEP_WAIT);
    wreq_d     = (state_d == ST_WAKE_WAIT) && (state_q != ST_WAKE_WAIT);

    if (state_q == ST_RUN && state_d == ST_RUN && !trigger && !pipe_active)
      idle_cnt_d = (idle_cnt_q < THR) ? idle_cnt_q + 1'b1 : idle_cnt_q;

    if (state_q == ST_SLEEP_WAIT) begin
      if (state_d == ST_SLEEP_WAIT) pend_d = pend_now;
      if (wake_pend) cause_d = pend_q ? (cause_q | wake_hits) : wake_hits;
    end

    if (state_q == ST_ASLEEP && wake_pend) cause_d = wake_hits;
  end

  assign drain_req      = drain_q;
  assign sleep_request  = sreq_q;
  assign wakeup_request = wreq_q;
  assign wake_cause     = cause_q;
  assign gen_state      = state_q;

endmodule

// File: tb/tb_sleep_request_gen.sv
// Self-checking bench for sleep_request_gen: directed scenarios plus a randomized
// run against a cycle-level behavioural model with an emulated sleep controller.
module tb_sleep_request_gen;

  localparam int THR = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wfi_valid = 1'b0;
  logic       pipe_active = 1'b0;
  logic       pipe_empty = 1'b0;
  logic       auto_sleep_en = 1'b0;
  logic [3:0] wake_src = '0;
  logic [3:0] wake_mask = '0;
  logic       sleep_state = 1'b0;
  logic       drain_req, sleep_request, wakeup_request;
  logic [3:0] wake_cause;
  logic [2:0] gen_state;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (phase numbers are the observable gen_state codes)
  int         m_phase = 0;
  int         m_idle = 0;
  bit         m_pend = 0;
  logic       m_drain = 0, m_sreq = 0, m_wreq = 0;
  logic [3:0] m_cause = '0;

  sleep_request_gen #(.NUM_WAKE_SRC(4), .IDLE_THRESHOLD(THR), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wfi_valid(wfi_valid), .pipe_active(pipe_active),
    .pipe_empty(pipe_empty), .auto_sleep_en(auto_sleep_en), .wake_src(wake_src),
    .wake_mask(wake_mask), .sleep_state(sleep_state), .drain_req(drain_req),
    .sleep_request(sleep_request), .wakeup_request(wakeup_request),
    .wake_cause(wake_cause), .gen_state(gen_state)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs();
    return {gen_state, drain_req, sleep_request, wakeup_request, wake_cause};
  endfunction

  function automatic logic [10:0] ex(int s, logic d, logic sr, logic wr, logic [3:0] c);
    return {s[2:0], d, sr, wr, c};
  endfunction

  function automatic logic [10:0] model_vec();
    return {m_phase[2:0], m_drain, m_sreq, m_wreq, m_cause};
  endfunction

  task automatic model_clk();
    logic [3:0] hits = wake_src & wake_mask;
    bit wp = |hits;
    bit fire;
    int nxt;
    if (rst) begin
      m_phase = 0; m_idle = 0; m_pend = 0;
      m_drain = 0; m_sreq = 0; m_wreq = 0; m_cause = '0;
      return;
    end
    nxt = m_phase;
    case (m_phase)
      0: begin
        fire = wfi_valid || (auto_sleep_en && !pipe_active && m_idle == THR - 1);
        if (fire && !wp) nxt = 1;
        if (fire || pipe_active) m_idle = 0;
        else if (m_idle < THR) m_idle++;
      end
      1: if (wp) nxt = 0; else if (pipe_empty && !sleep_state) nxt = 2;
      2: begin
        if (wp) begin
          m_cause = m_pend ? (m_cause | hits) : hits;
          m_pend = 1;
        end
        if (sleep_state) nxt = m_pend ? 4 : 3;
      end
      3: if (wp) begin m_cause = hits; nxt = 4; end
      4: if (!sleep_state) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt != 0) m_idle = 0;
    if (nxt != 2) m_pend = 0;
    m_sreq  = (m_phase == 1 && nxt == 2);
    m_wreq  = (nxt == 4 && m_phase != 4);
    m_drain = (nxt != 0);
    m_phase = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (obs() !== ex(0,0,0,0,0)) begin errors++; $display("FAIL reset_state got=%h exp=%h", obs(), ex(0,0,0,0,0)); end
    rst = 1'b0;
    step();
    checks++; if (obs() !== ex(0,0,0,0,0)) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs(), ex(0,0,0,0,0)); end
    $display("test_reset done");
  endtask

  task automatic test_wfi_sleep();
    do_reset();
    pipe_empty = 1'b1; wfi_valid = 1'b1;
    step();
    wfi_valid = 1'b0;
    checks++; if (obs() !== ex(1,1,0,0,0)) begin errors++; $display("FAIL wfi_drain got=%h exp=%h", obs(), ex(1,1,0,0,0)); end
    step();
    checks++; if (obs() !== ex(2,1,1,0,0)) begin errors++; $display("FAIL sleep_req_pulse got=%h exp=%h", obs(), ex(2,1,1,0,0)); end
    sleep_state = 1'b1;
    step();
    checks++; if (obs() !== ex(3,1,0,0,0)) begin errors++; $display("FAIL asleep_entry got=%h exp=%h", obs(), ex(3,1,0,0,0)); end
    step();
    checks++; if (obs() !== ex(3,1,0,0,0)) begin errors++; $display("FAIL asleep_hold got=%h exp=%h", obs(), ex(3,1,0,0,0)); end
    $display("test_wfi_sleep done");
  endtask

  task automatic test_wake_cause();
    wake_mask = 4'b0010; wake_src = 4'b0110;
    step();
    checks++; if (obs() !== ex(4,1,0,1,4'b0010)) begin errors++; $display("FAIL wake_capture got=%h exp=%h", obs(), ex(4,1,0,1,4'b0010)); end
    wake_src = 4'b0000;
    step();
    checks++; if (obs() !== ex(4,1,0,0,4'b0010)) begin errors++; $display("FAIL wake_pulse_single got=%h exp=%h", obs(), ex(4,1,0,0,4'b0010)); end
    sleep_state = 1'b0;
    step();
    checks++; if (obs() !== ex(0,0,0,0,4'b0010)) begin errors++; $display("FAIL wake_to_run got=%h exp=%h", obs(), ex(0,0,0,0,4'b0010)); end
    wake_mask = 4'b0000;
    $display("test_wake_cause done");
  endtask

  task automatic test_auto_sleep();
    do_reset();
    pipe_empty = 1'b0; auto_sleep_en = 1'b1; pipe_active = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (gen_state !== ((i == 16) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL auto_sleep cycle=%0d got=%0d exp=%0d", i, gen_state, (i == 16) ? 1 : 0);
      end
    end
    do_reset();
    for (int i = 1; i <= 26; i++) begin
      pipe_active = (i == 10);
      step();
      checks++;
      if (gen_state !== ((i == 26) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL auto_sleep_restart cycle=%0d got=%0d exp=%0d", i, gen_state, (i == 26) ? 1 : 0);
      end
    end
    pipe_active = 1'b0; auto_sleep_en = 1'b0;
    $display("test_auto_sleep done");
  endtask

  task automatic test_wfi_wake_nop();
    do_reset();
    pipe_empty = 1'b1; wake_src = 4'b0001; wake_mask = 4'b0001; wfi_valid = 1'b1;
    step();
    wfi_valid = 1'b0;
    checks++; if (obs() !== ex(0,0,0,0,0)) begin errors++; $display("FAIL wfi_nop got=%h exp=%h", obs(), ex(0,0,0,0,0)); end
    step();
    checks++; if (obs() !== ex(0,0,0,0,0)) begin errors++; $display("FAIL wfi_nop_hold got=%h exp=%h", obs(), ex(0,0,0,0,0)); end
    wake_src = '0; wake_mask = '0;
    $display("test_wfi_wake_nop done");
  endtask

  task automatic test_drain_abort();
    do_reset();
    pipe_empty = 1'b0; wfi_valid = 1'b1;
    step();
    wfi_valid = 1'b0;
    step();
    checks++; if (obs() !== ex(1,1,0,0,0)) begin errors++; $display("FAIL drain_hold got=%h exp=%h", obs(), ex(1,1,0,0,0)); end
    wake_src = 4'b1000; wake_mask = 4'b1000;
    step();
    checks++; if (obs() !== ex(0,0,0,0,0)) begin errors++; $display("FAIL drain_abort got=%h exp=%h", obs(), ex(0,0,0,0,0)); end
    wake_src = '0;
    step();
    checks++; if (obs() !== ex(0,0,0,0,0)) begin errors++; $display("FAIL drain_abort_run got=%h exp=%h", obs(), ex(0,0,0,0,0)); end
    $display("test_drain_abort done");
  endtask

  task automatic test_sleep_wait_wake();
    pipe_empty = 1'b1; wfi_valid = 1'b1;
    step();
    wfi_valid = 1'b0;
    step();
    checks++; if (obs() !== ex(2,1,1,0,0)) begin errors++; $display("FAIL sw_entry got=%h exp=%h", obs(), ex(2,1,1,0,0)); end
    wake_src = 4'b0100; wake_mask = 4'b1111;
    step();
    checks++; if (obs() !== ex(2,1,0,0,4'b0100)) begin errors++; $display("FAIL sw_latch got=%h exp=%h", obs(), ex(2,1,0,0,4'b0100)); end
    wake_src = '0;
    step();
    sleep_state = 1'b1;
    step();
    checks++; if (obs() !== ex(4,1,0,1,4'b0100)) begin errors++; $display("FAIL sw_direct_wake got=%h exp=%h", obs(), ex(4,1,0,1,4'b0100)); end
    step();
    checks++; if (obs() !== ex(4,1,0,0,4'b0100)) begin errors++; $display("FAIL sw_wake_wait got=%h exp=%h", obs(), ex(4,1,0,0,4'b0100)); end
    sleep_state = 1'b0;
    step();
    checks++; if (obs() !== ex(0,0,0,0,4'b0100)) begin errors++; $display("FAIL sw_to_run got=%h exp=%h", obs(), ex(0,0,0,0,4'b0100)); end
    wake_mask = '0;
    $display("test_sleep_wait_wake done");
  endtask

  task automatic test_reset_asleep();
    pipe_empty = 1'b1; wfi_valid = 1'b1;
    step();
    wfi_valid = 1'b0;
    step();
    sleep_state = 1'b1;
    step();
    checks++; if (obs() !== ex(3,1,0,0,4'b0100)) begin errors++; $display("FAIL pre_reset_asleep got=%h exp=%h", obs(), ex(3,1,0,0,4'b0100)); end
    rst = 1'b1;
    step();
    checks++; if (obs() !== ex(0,0,0,0,0)) begin errors++; $display("FAIL reset_in_asleep got=%h exp=%h", obs(), ex(0,0,0,0,0)); end
    rst = 1'b0; sleep_state = 1'b0;
    step();
    checks++; if (obs() !== ex(0,0,0,0,0)) begin errors++; $display("FAIL after_reset_asleep got=%h exp=%h", obs(), ex(0,0,0,0,0)); end
    $display("test_reset_asleep done");
  endtask

  task automatic test_back_to_back();
    pipe_empty = 1'b0; wfi_valid = 1'b1; pipe_active = 1'b1;
    step();
    wfi_valid = 1'b0; pipe_active = 1'b0; pipe_empty = 1'b1;
    checks++; if (obs() !== ex(1,1,0,0,0)) begin errors++; $display("FAIL wfi_and_active got=%h exp=%h", obs(), ex(1,1,0,0,0)); end
    step();
    checks++; if (obs() !== ex(2,1,1,0,0)) begin errors++; $display("FAIL wfi_and_active_sleep got=%h exp=%h", obs(), ex(2,1,1,0,0)); end
    do_reset();
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    int  ctl_delay = 0;
    bit  ctl_goal = 0;
    bit  idle_mode = 0;
    logic prev_sreq = 0, prev_wreq = 0;
    int  local_err = 0;
    sleep_state = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) idle_mode = ($urandom_range(0, 1) == 1);
      rst           = ($urandom_range(0, 399) == 0);
      wfi_valid     = ($urandom_range(0, 15) == 0);
      pipe_active   = idle_mode ? 1'b0 : ($urandom_range(0, 2) == 0);
      pipe_empty    = ($urandom_range(0, 1) == 1);
      auto_sleep_en = ($urandom_range(0, 3) != 0);
      wake_src      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      wake_mask     = 4'($urandom);
      step();
      // Emulated sleep controller responds to the requests after a random delay
      if (rst) begin ctl_goal = 0; ctl_delay = 1; end
      else if (m_sreq) begin ctl_goal = 1; ctl_delay = $urandom_range(1, 4); end
      else if (m_wreq) begin ctl_goal = 0; ctl_delay = $urandom_range(1, 4); end
      if (ctl_delay > 0) begin
        ctl_delay--;
        if (ctl_delay == 0) sleep_state = ctl_goal;
      end
      checks++;
      if (obs() !== model_vec()) begin
        errors++; local_err++;
        if (local_err <= 10) $display("FAIL random_model cycle=%0d got=%h exp=%h", i, obs(), model_vec());
      end
      checks++;
      if ((sleep_request && wakeup_request) || (sleep_request && prev_sreq) || (wakeup_request && prev_wreq)) begin
        errors++; $display("FAIL pulse_rules cycle=%0d sreq=%b wreq=%b prev=%b%b exp=no_overlap", i, sleep_request, wakeup_request, prev_sreq, prev_wreq);
      end
      prev_sreq = sleep_request;
      prev_wreq = wakeup_request;
    end
    rst = 1'b0; wfi_valid = 1'b0; wake_src = '0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_wfi_sleep();
    test_wake_cause();
    test_auto_sleep();
    test_wfi_wake_nop();
    test_drain_abort();
    test_sleep_wait_wake();
    test_reset_asleep();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
